frame_payload_extractor: RTL

//  Consumes the aligned byte stream from frame_aligner, strips the header bytes and

---
 rtl/frame_pkg.sv | 21 ++
 rtl/payload_fifo.sv | 61 ++++++
 rtl/frame_payload_extractor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared types and default sizing for the frame payload extraction path.
package frame_pkg;

  localparam int DEF_HDR_LEN       = 2;
  localparam int DEF_PAYLOAD_BYTES = 10;
  localparam int DEF_DEPTH         = 32;
  localparam int DEF_CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2
  } state_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/payload_fifo.sv
// Commit/rollback FIFO: written entries stay invisible to the reader until committed,
// and a rollback discards everything written since the last commit.
module payload_fifo
  import frame_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  fifo_entry_t   wr_entry,
  input  logic          commit,
  input  logic          rollback,
  input  logic          rd_en,
  output fifo_entry_t   rd_entry,
  output logic          rd_valid,
  output logic [PW-1:0] level,
  output logic [PW-1:0] free
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_base;

  // A rollback and a fresh write may share a cycle, so writes land at the rolled-back pointer.
  always_comb begin
    wr_base      = rollback ? commit_ptr_q : wr_ptr_q;
    wr_ptr_d     = wr_base + {{(PW-1){1'b0}}, wr_en};
    commit_ptr_d = commit ? wr_ptr_d : commit_ptr_q;
    rd_ptr_d     = rd_ptr_q + {{(PW-1){1'b0}}, (rd_en & rd_valid)};
  end

  assign rd_valid = (rd_ptr_q != commit_ptr_q);
  assign rd_entry = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign level    = commit_ptr_q - rd_ptr_q;
  assign free     = PW'(DEPTH) - (wr_base - rd_ptr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_base[AW-1:0]] <= wr_entry;
    end
  end

endmodule

// File: rtl/frame_payload_extractor.sv
// Strips frame headers, buffers each payload until it is complete and emits only whole
// payloads as a valid/ready byte stream, with saturating good/dropped frame counters.
module frame_payload_extractor
  import frame_pkg::*;
#(
  parameter int HDR_LEN       = DEF_HDR_LEN,
  parameter int PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic [3:0]             in_pos,
  input  logic                   frame_detect,
  output logic [7:0]             out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       frames_ok,
  output logic [CNT_W-1:0]       frames_dropped,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int              PW        = $clog2(DEPTH) + 1;
  localparam logic [3:0]      FIRST_POS = 4'(HDR_LEN);
  localparam logic [3:0]      LAST_POS  = 4'(HDR_LEN + PAYLOAD_BYTES - 1);
  localparam logic [PW-1:0]   NEED      = PW'(PAYLOAD_BYTES);

  state_t           state_q, state_d;
  logic [3:0]       exp_q, exp_d;
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W:0]   drop_sum;
  logic             beat, abort, idle_eval;
  logic             wr_en, commit, ok_inc;
  logic [1:0]       drop_inc;
  fifo_entry_t      wr_entry, rd_entry;
  logic [PW-1:0]    free, level;

  assign beat  = in_valid & frame_detect;
  assign abort = (state_q == COLLECT) &&
                 (!frame_detect || (in_valid && (in_pos != exp_q)));

  // An aborting beat is re-examined as a potential frame start in the same cycle.
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    wr_en         = 1'b0;
    commit        = 1'b0;
    ok_inc        = 1'b0;
    drop_inc      = 2'd0;
    wr_entry      = '0;
    wr_entry.data = in_data;
    idle_eval     = (state_q == IDLE) || abort;

    case (state_q)
      COLLECT: begin
        if (abort) begin
          state_d  = IDLE;
          drop_inc = 2'd1;
        end else if (in_valid) begin
          wr_en = 1'b1;
          exp_d = exp_q + 4'd1;
          if (in_pos == LAST_POS) begin
            wr_entry.eop = 1'b1;
            commit       = 1'b1;
            ok_inc       = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      DROP: begin
        if (!frame_detect || (in_valid && (in_pos == LAST_POS))) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (idle_eval && beat && (in_pos == FIRST_POS)) begin
      if (free >= NEED) begin
        wr_en        = 1'b1;
        wr_entry.sop = 1'b1;
        exp_d        = FIRST_POS + 4'd1;
        state_d      = COLLECT;
      end else begin
        drop_inc = drop_inc + 2'd1;
        state_d  = DROP;
      end
    end
  end

  // Counters stick at all-ones; an abort plus an overflow start can drop two frames at once.
  always_comb begin
    ok_d     = (ok_inc && (ok_q != '1)) ? ok_q + 1'b1 : ok_q;
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      exp_q   <= '0;
      ok_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      ok_q    <= ok_d;
      drop_q  <= drop_d;
    end
  end

  payload_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_entry (wr_entry),
    .commit   (commit),
    .rollback (abort),
    .rd_en    (out_ready),
    .rd_entry (rd_entry),
    .rd_valid (out_valid),
    .level    (level),
    .free     (free)
  );

  assign out_data       = rd_entry.data;
  assign out_sop        = rd_entry.sop;
  assign out_eop        = rd_entry.eop;
  assign frames_ok      = ok_q;
  assign frames_dropped = drop_q;
  assign fifo_level     = level;

endmodule
